// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage in front of a combinational ALU.
// It accepts one operand/opcode request, drives it into the ALU, waits a
// programmable settle time and then captures the ALU result for a
// valid/ready consumer. In sweep mode it walks every opcode for one operand
// pair before returning to idle.
module alu_op_sequencer #(
    parameter int WIDTH  = 4,
    parameter int OPW    = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    // request side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_opcode,
    input  logic             in_sweep,
    // ALU side
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_x,
    input  logic [WIDTH-1:0] alu_y,
    // result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [OPW-1:0]   out_opcode,
    // status
    output logic             busy,
    output logic             done
);

    // A settle time below one cycle still needs one DRIVE cycle.
    localparam int              SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int              CNT_W      = $clog2(SETTLE_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_EFF);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam logic [OPW-1:0]  LAST_OP    = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_opcode;
    logic             r_sweep;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out_x;
    logic [WIDTH-1:0] r_out_y;
    logic [OPW-1:0]   r_out_opcode;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;

    // Sequencer FSM: every output is a register updated alongside the state.
    // NOTE: all state here is written with <= so every register samples the
    // pre-edge values of the others; blocking writes would create ordering bugs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_opcode     <= '0;
            r_sweep      <= 1'b0;
            r_cnt        <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_opcode <= '0;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless re-armed below
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_sweep    <= in_sweep;
                        r_opcode   <= in_sweep ? '0 : in_opcode;
                        r_cnt      <= CNT_LOAD;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_cnt <= r_cnt - CNT_LAST;
                    // last settle cycle: ALU outputs are stable, capture them
                    if (r_cnt == CNT_LAST) begin
                        r_out_x      <= alu_x;
                        r_out_y      <= alu_y;
                        r_out_opcode <= r_opcode;
                        r_out_valid  <= 1'b1;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_sweep && (r_opcode != LAST_OP)) begin
                            r_opcode <= r_opcode + 1'b1;
                            r_cnt    <= CNT_LOAD;
                            r_state  <= DRIVE;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_opcode = r_opcode;
    assign out_valid  = r_out_valid;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign out_opcode = r_out_opcode;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
